// File: rtl/mul8b_seq_ctrl_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller:
// state and step encodings, the per-step shift table and step-selection helpers.
package mul8b_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef logic [1:0] step_t;

    // Step order: low/low, high-a/low-b, low-a/high-b, high/high
    localparam step_t STEP_LL = 2'd0;
    localparam step_t STEP_HL = 2'd1;
    localparam step_t STEP_LH = 2'd2;
    localparam step_t STEP_HH = 2'd3;

    localparam logic [3:0] SH0 = 4'd0;
    localparam logic [3:0] SH1 = 4'd4;
    localparam logic [3:0] SH2 = 4'd4;
    localparam logic [3:0] SH3 = 4'd8;

    typedef struct packed {
        logic  found;
        step_t step;
    } pick_t;

    function automatic logic [3:0] stepShift(input step_t s);
        logic [3:0] sh;
        case (s)
            STEP_LL: sh = SH0;
            STEP_HL: sh = SH1;
            STEP_LH: sh = SH2;
            default: sh = SH3;
        endcase
        return sh;
    endfunction

    function automatic logic [3:0] activeMask(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] m;
        m[0] = (|a[3:0]) & (|b[3:0]);
        m[1] = (|a[7:4]) & (|b[3:0]);
        m[2] = (|a[3:0]) & (|b[7:4]);
        m[3] = (|a[7:4]) & (|b[7:4]);
        return m;
    endfunction

    function automatic logic [3:0] laterMask(input step_t s);
        logic [3:0] m;
        case (s)
            STEP_LL: m = 4'b1110;
            STEP_HL: m = 4'b1100;
            STEP_LH: m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Lowest-numbered set bit wins
    function automatic pick_t firstActive(input logic [3:0] m);
        pick_t p;
        p.found = 1'b1;
        if (m[0])      p.step = STEP_LL;
        else if (m[1]) p.step = STEP_HL;
        else if (m[2]) p.step = STEP_LH;
        else if (m[3]) p.step = STEP_HH;
        else begin
            p.found = 1'b0;
            p.step  = STEP_LL;
        end
        return p;
    endfunction

endpackage

// File: rtl/mul8b_seq_ctrl_if.sv
// Operand/product handshake bundle between the bus-side source/sink and the controller.
interface mul8b_seq_ctrl_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    modport master (
        output in_valid, in_a, in_b, abort, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, abort, out_ready,
        output in_ready, out_valid, out_p, busy
    );

endinterface

// File: rtl/mul4b.sv
// Combinational unsigned 4x4 multiplier array shared by all steps.
module mul4b (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    assign p_o = {4'h0, a_i} * {4'h0, b_i};

endmodule

// File: rtl/mul8b_seq_ctrl_nib_sel.sv
// Picks the operand nibbles for one step and flags whether that step contributes anything.
module nib_sel
    import mul8b_seq_ctrl_pkg::*;
(
    input  logic [7:0] opA_i,
    input  logic [7:0] opB_i,
    input  step_t      step_i,
    output logic [3:0] nibA_o,
    output logic [3:0] nibB_o,
    output logic       active_o
);

    // Step bit 0 selects the high A nibble, step bit 1 the high B nibble
    always_comb begin
        nibA_o   = step_i[0] ? opA_i[7:4] : opA_i[3:0];
        nibB_o   = step_i[1] ? opB_i[7:4] : opB_i[3:0];
        active_o = (|nibA_o) & (|nibB_o);
    end

endmodule

// File: rtl/mul8b_seq_ctrl.sv
// Sequential unsigned 8x8 multiplier: one shared 4x4 array, one nibble pair per cycle,
// shift-accumulated into a 16-bit result held until the consumer takes it.
module mul8b_seq_ctrl
    import mul8b_seq_ctrl_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    mul8b_seq_ctrl_if.slave   bus
);

    state_t      state_q, state_d;
    logic [7:0]  aOp_q, aOp_d;
    logic [7:0]  bOp_q, bOp_d;
    step_t       step_q, step_d;
    logic [15:0] acc_q, acc_d;

    logic [3:0]  nibA, nibB;
    logic [7:0]  pp;
    logic        stepActive;
    logic [3:0]  inMask, opMask;
    pick_t       firstIn, nextPick;
    logic [15:0] ppShifted;

    nib_sel u_nib_sel (
        .opA_i    (aOp_q),
        .opB_i    (bOp_q),
        .step_i   (step_q),
        .nibA_o   (nibA),
        .nibB_o   (nibB),
        .active_o (stepActive)
    );

    mul4b u_mul4b (
        .a_i (nibA),
        .b_i (nibB),
        .p_o (pp)
    );

    // Without skipping every step counts as active, so the search degenerates to 0,1,2,3
    assign inMask    = SKIP_ZERO ? activeMask(bus.in_a, bus.in_b) : 4'b1111;
    assign opMask    = SKIP_ZERO ? activeMask(aOp_q, bOp_q) : 4'b1111;
    assign firstIn   = firstActive(inMask);
    assign nextPick  = firstActive(opMask & laterMask(step_q));
    assign ppShifted = {8'h00, pp} << stepShift(step_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            aOp_q   <= '0;
            bOp_q   <= '0;
            step_q  <= STEP_LL;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            aOp_q   <= aOp_d;
            bOp_q   <= bOp_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        aOp_d   = aOp_q;
        bOp_d   = bOp_q;
        step_d  = step_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    aOp_d   = bus.in_a;
                    bOp_d   = bus.in_b;
                    acc_d   = '0;
                    step_d  = firstIn.found ? firstIn.step : STEP_LL;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    step_d  = STEP_LL;
                end else begin
                    if (stepActive) begin
                        acc_d = acc_q + ppShifted;
                    end
                    if (nextPick.found) begin
                        step_d = nextPick.step;
                    end else begin
                        step_d  = STEP_LL;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Abort takes priority: a simultaneous out_ready does not count as a transfer
                if (bus.abort || bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_p     = (state_q == ST_DONE) ? acc_q : 16'h0000;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mul8b_seq_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic on both SKIP_ZERO variants,
// compared cycle by cycle against a transaction-level reference model.
module tb_mul8b_seq_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_WORK = 1;
    localparam int M_HOLD = 2;

    logic clk;
    logic rst_n;

    logic        inValid  [2];
    logic [7:0]  inA      [2];
    logic [7:0]  inB      [2];
    logic        abortIn  [2];
    logic        outReady [2];
    logic        inReadyO [2];
    logic        outValidO[2];
    logic [15:0] outPO    [2];
    logic        busyO    [2];

    int          mState [2];
    int          mRemain[2];
    logic [15:0] mProd  [2];
    int          mDone  [2];
    int          obsDone[2];

    int testCount;
    int failCount;

    mul8b_seq_ctrl_if bus0 ();
    mul8b_seq_ctrl_if bus1 ();

    mul8b_seq_ctrl #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mul8b_seq_ctrl #(.SKIP_ZERO(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.in_valid  = inValid[0];
    assign bus0.in_a      = inA[0];
    assign bus0.in_b      = inB[0];
    assign bus0.abort     = abortIn[0];
    assign bus0.out_ready = outReady[0];
    assign bus1.in_valid  = inValid[1];
    assign bus1.in_a      = inA[1];
    assign bus1.in_b      = inB[1];
    assign bus1.abort     = abortIn[1];
    assign bus1.out_ready = outReady[1];

    assign inReadyO[0]  = bus0.in_ready;
    assign outValidO[0] = bus0.out_valid;
    assign outPO[0]     = bus0.out_p;
    assign busyO[0]     = bus0.busy;
    assign inReadyO[1]  = bus1.in_ready;
    assign outValidO[1] = bus1.out_valid;
    assign outPO[1]     = bus1.out_p;
    assign busyO[1]     = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Latency follows from how many nibble pairs are both non-zero
    function automatic int expLatency(input bit skip, input logic [7:0] a, input logic [7:0] b);
        int nzA;
        int nzB;
        if (!skip) return 4;
        nzA = int'(a[3:0] != 0) + int'(a[7:4] != 0);
        nzB = int'(b[3:0] != 0) + int'(b[7:4] != 0);
        return (nzA * nzB == 0) ? 1 : nzA * nzB;
    endfunction

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            mState[d]  = M_IDLE;
            mRemain[d] = 0;
            mProd[d]   = 16'h0000;
        end
    endtask

    task automatic modelStep(input int d, input logic v, input logic [7:0] a, input logic [7:0] b,
                             input logic ab, input logic rdy);
        case (mState[d])
            M_IDLE: begin
                if (v) begin
                    mState[d]  = M_WORK;
                    mRemain[d] = expLatency(d == 1, a, b);
                    mProd[d]   = 16'(a) * 16'(b);
                end
            end
            M_WORK: begin
                if (ab) begin
                    mState[d] = M_IDLE;
                end else begin
                    mRemain[d]--;
                    if (mRemain[d] == 0) mState[d] = M_HOLD;
                end
            end
            default: begin
                if (ab || rdy) mState[d] = M_IDLE;
                if (!ab && rdy) mDone[d]++;
            end
        endcase
    endtask

    task automatic checkModel(input int d);
        checkOutput($sformatf("dut%0d in_ready", d), 16'(inReadyO[d]), 16'(mState[d] == M_IDLE));
        checkOutput($sformatf("dut%0d out_valid", d), 16'(outValidO[d]), 16'(mState[d] == M_HOLD));
        checkOutput($sformatf("dut%0d busy", d), 16'(busyO[d]), 16'(mState[d] != M_IDLE));
        checkOutput($sformatf("dut%0d out_p", d), outPO[d], (mState[d] == M_HOLD) ? mProd[d] : 16'h0000);
    endtask

    // Called at a falling edge: check, drive, advance the model on the rising edge
    task automatic applyStimulus(input int d, input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic ab, input logic rdy);
        checkModel(d);
        if (outValidO[d] && rdy && !ab) obsDone[d]++;
        inValid[d]  = v;
        inA[d]      = a;
        inB[d]      = b;
        abortIn[d]  = ab;
        outReady[d] = rdy;
        @(posedge clk);
        modelStep(d, v, a, b, ab, rdy);
        @(negedge clk);
    endtask

    function automatic logic [7:0] randOperand();
        logic [7:0] x;
        x = 8'($urandom);
        case ($urandom_range(0, 5))
            0: x[3:0] = 4'h0;
            1: x[7:4] = 4'h0;
            2: x = 8'h00;
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        logic       v, ab, rdy, wasIdle;
        logic [7:0] curA, curB;

        testCount = 0;
        failCount = 0;
        for (int d = 0; d < 2; d++) begin
            inValid[d] = 1'b0; inA[d] = 8'h00; inB[d] = 8'h00;
            abortIn[d] = 1'b0; outReady[d] = 1'b0;
            mDone[d] = 0; obsDone[d] = 0;
        end
        resetModel();
        rst_n = 1'b0;
        #3;
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset dut%0d in_ready", d), 16'(inReadyO[d]), 16'h1);
            checkOutput($sformatf("reset dut%0d out_valid", d), 16'(outValidO[d]), 16'h0);
            checkOutput($sformatf("reset dut%0d out_p", d), outPO[d], 16'h0000);
            checkOutput($sformatf("reset dut%0d busy", d), 16'(busyO[d]), 16'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed 4-cycle latency, largest product
        applyStimulus(0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        repeat (3) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t1 valid before 4 clocks", 16'(outValidO[0]), 16'h0);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t1 valid at 4 clocks", 16'(outValidO[0]), 16'h1);
        checkOutput("t1 product", outPO[0], 16'hFE01);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Consumer back-pressure; a new in_valid meanwhile must be ignored
        applyStimulus(0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        repeat (4) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2 held product", outPO[0], 16'h03A8);
            checkOutput("t2 held valid", 16'(outValidO[0]), 16'h1);
            checkOutput("t2 in_ready low", 16'(inReadyO[0]), 16'h0);
            applyStimulus(0, 1'b1, 8'h55, 8'h66, 1'b0, 1'b0);
        end
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Zero-skipping: single active step, then no active step
        applyStimulus(1, 1'b1, 8'h10, 8'h01, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t3 single-step valid", 16'(outValidO[1]), 16'h1);
        checkOutput("t3 single-step product", outPO[1], 16'h0010);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        applyStimulus(1, 1'b1, 8'h00, 8'hAB, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t3 zero-operand valid", 16'(outValidO[1]), 16'h1);
        checkOutput("t3 zero-operand product", outPO[1], 16'h0000);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Abort while the third step is being accumulated, then a clean rerun
        applyStimulus(0, 1'b1, 8'h9C, 8'h7B, 1'b0, 1'b0);
        repeat (2) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        checkOutput("t4 idle after abort", 16'(inReadyO[0]), 16'h1);
        checkOutput("t4 no valid after abort", 16'(outValidO[0]), 16'h0);
        repeat (4) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 8'h9C, 8'h7B, 1'b0, 1'b0);
        repeat (4) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t4 rerun product", outPO[0], 16'h4AF4);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset in the middle of an operation
        applyStimulus(0, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5 async in_ready", 16'(inReadyO[0]), 16'h1);
        checkOutput("t5 async out_valid", 16'(outValidO[0]), 16'h0);
        checkOutput("t5 async busy", 16'(busyO[0]), 16'h0);
        checkOutput("t5 async out_p", outPO[0], 16'h0000);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0);
        repeat (4) applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("t5 post-reset product", outPO[0], 16'h0E10);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

        // Randomized traffic; operands are held until the controller accepts them
        for (int d = 0; d < 2; d++) begin
            mDone[d]   = 0;
            obsDone[d] = 0;
            curA = randOperand();
            curB = randOperand();
            for (int c = 0; c < 8000; c++) begin
                v       = ($urandom_range(0, 3) != 0);
                ab      = ($urandom_range(0, 19) == 0);
                rdy     = ($urandom_range(0, 2) != 0);
                wasIdle = (mState[d] == M_IDLE);
                applyStimulus(d, v, curA, curB, ab, rdy);
                if (wasIdle && v) begin
                    curA = randOperand();
                    curB = randOperand();
                end
            end
            applyStimulus(d, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
            checkOutput($sformatf("dut%0d completed transfers", d), 16'(obsDone[d]), 16'(mDone[d]));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
